// File: rtl/replay_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : replay_scheduler
// Brief   : Gamma-cycle sequencer for ping-pong replay buffers and output mux.
// Revision: 1.0
// ============================================================================
module replay_scheduler #(
    parameter int GAMMA_LEN   = 16,
    parameter int READ_STRIDE = 2,
    parameter int NUM_INPUTS  = 2,
    localparam int AW         = $clog2(GAMMA_LEN),
    localparam int MW         = $clog2(NUM_INPUTS)
) (
    input  logic          clk,
    input  logic          grst,
    input  logic          start,
    input  logic          stop,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic          bank_sel,
    output logic [MW-1:0] mux_sel,
    output logic          gamma_start,
    output logic          busy
);

    localparam int SW = (READ_STRIDE > 1) ? $clog2(READ_STRIDE) : 1;
    localparam int PW = AW + SW;
    localparam logic [AW-1:0] CYC_LAST = AW'(GAMMA_LEN - 1);
    localparam logic [MW-1:0] MUX_LAST = MW'(NUM_INPUTS - 1);
    localparam logic [AW:0]   RD_CNT   = (AW+1)'(GAMMA_LEN / READ_STRIDE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cyc, cyc_nx;
    logic          stop_pend, pend_nx;
    logic          bank_nx;
    logic [MW-1:0] mux_nx;
    logic          gs_nx;
    logic          rdv_nx;
    logic [PW-1:0] rd_prod;

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state     <= IDLE;
            cyc       <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            cyc       <= cyc_nx;
            stop_pend <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = stop_pend;
        bank_nx  = bank_sel;
        mux_nx   = mux_sel;
        gs_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = PRIME;
                    gs_nx    = 1'b1;
                end
            end
            PRIME: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (cyc == CYC_LAST) begin
                    // First replay gamma keeps mux on input 0
                    state_nx = RUN;
                    bank_nx  = ~bank_sel;
                    gs_nx    = 1'b1;
                end
            end
            RUN: begin
                pend_nx = stop_pend | stop;
                if (cyc == CYC_LAST) begin
                    state_nx = pend_nx ? DRAIN : RUN;
                    bank_nx  = ~bank_sel;
                    mux_nx   = (mux_sel == MUX_LAST) ? '0 : mux_sel + 1'b1;
                    gs_nx    = 1'b1;
                end
            end
            DRAIN: begin
                if (cyc == CYC_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == IDLE) begin
            pend_nx = 1'b0;
            bank_nx = 1'b0;
            mux_nx  = '0;
        end
    end

    // GAMMA_LEN is a power of two, so the counter wraps on its own
    assign cyc_nx  = (state == IDLE || state_nx == IDLE) ? '0 : cyc + 1'b1;
    assign rdv_nx  = (state_nx == RUN || state_nx == DRAIN) && ({1'b0, cyc_nx} < RD_CNT);
    assign rd_prod = PW'(cyc_nx) * PW'(READ_STRIDE);

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            bank_sel    <= 1'b0;
            mux_sel     <= '0;
            gamma_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= (state_nx == PRIME) || (state_nx == RUN);
            wr_addr     <= ((state_nx == PRIME) || (state_nx == RUN)) ? cyc_nx : '0;
            rd_valid    <= rdv_nx;
            rd_addr     <= rdv_nx ? rd_prod[AW-1:0] : '0;
            bank_sel    <= bank_nx;
            mux_sel     <= mux_nx;
            gamma_start <= gs_nx;
            busy        <= (state_nx != IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_replay_scheduler.sv
`default_nettype none
// Bench for replay_scheduler: directed stimulus, gamma-level reference model.
module tb_replay_scheduler;

    localparam int G  = 8;
    localparam int RS = 2;
    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       grst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       wr_en, rd_valid, bank_sel, gamma_start, busy;
    logic [2:0] wr_addr, rd_addr;
    logic [0:0] mux_sel;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: cycles since start; gamma index and position derive from it
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_stop_g = -1;

    replay_scheduler #(.GAMMA_LEN(G), .READ_STRIDE(RS), .NUM_INPUTS(NI)) dut (
        .clk(clk), .grst(grst), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .bank_sel(bank_sel), .mux_sel(mux_sel), .gamma_start(gamma_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    always @(posedge clk) begin
        int g, c;
        if (grst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_stop_g = -1;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_t      = 0;
                m_stop_g = -1;
            end
        end else begin
            g = m_t / G;
            c = m_t % G;
            if (g == 0 && stop) begin
                m_active = 1'b0;
            end else begin
                if (g >= 1 && stop && m_stop_g < 0) m_stop_g = g;
                if (m_stop_g >= 0 && g == m_stop_g + 1 && c == G - 1) m_active = 1'b0;
                else m_t++;
            end
        end
    end

    always @(negedge clk) begin
        int g, c;
        bit drain, rv;
        if (!m_active) begin
            chk("idle_wr_en", wr_en, 0);
            chk("idle_wr_addr", wr_addr, 0);
            chk("idle_rd_valid", rd_valid, 0);
            chk("idle_rd_addr", rd_addr, 0);
            chk("idle_bank_sel", bank_sel, 0);
            chk("idle_mux_sel", mux_sel, 0);
            chk("idle_gamma_start", gamma_start, 0);
            chk("idle_busy", busy, 0);
        end else begin
            g     = m_t / G;
            c     = m_t % G;
            drain = (m_stop_g >= 0) && (g == m_stop_g + 1);
            rv    = (g >= 1) && (c < G / RS);
            chk("busy", busy, 1);
            chk("gamma_start", gamma_start, (c == 0) ? 1 : 0);
            chk("wr_en", wr_en, drain ? 0 : 1);
            if (!drain) chk("wr_addr", wr_addr, c);
            chk("bank_sel", bank_sel, g % 2);
            chk("mux_sel", mux_sel, (g == 0) ? 0 : (g - 1) % NI);
            chk("rd_valid", rd_valid, rv ? 1 : 0);
            if (g >= 1) chk("rd_addr", rd_addr, rv ? c * RS : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_wr_en", wr_en, 0);
        grst = 1'b0;
        tick(1);

        // Prime, then three RUN gammas
        pulse_start();
        chk("lit_prime0_wr_addr", wr_addr, 0);
        chk("lit_prime0_gs", gamma_start, 1);
        tick(7);
        chk("lit_prime7_wr_addr", wr_addr, 7);
        chk("lit_prime7_rd_valid", rd_valid, 0);
        tick(1);
        chk("lit_run0_bank", bank_sel, 1);
        chk("lit_run0_gs", gamma_start, 1);
        chk("lit_run0_mux", mux_sel, 0);
        chk("lit_run0_rd_valid", rd_valid, 1);
        tick(3);
        chk("lit_run3_rd_addr", rd_addr, 6);
        tick(1);
        chk("lit_run4_rd_valid", rd_valid, 0);
        pulse_start();
        tick(3);
        chk("lit_run2g_mux", mux_sel, 1);
        chk("lit_run2g_bank", bank_sel, 0);
        tick(8);
        chk("lit_run3g_mux", mux_sel, 0);
        chk("lit_run3g_bank", bank_sel, 1);

        // Stop mid-gamma: finish gamma, drain one, then idle
        tick(3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(4);
        chk("lit_drain_wr_en", wr_en, 0);
        chk("lit_drain_rd_valid", rd_valid, 1);
        chk("lit_drain_busy", busy, 1);
        tick(7);
        chk("lit_drain7_rd_addr", rd_addr, 0);
        tick(1);
        chk("lit_after_drain_busy", busy, 0);
        stop = 1'b1;
        tick(2);
        stop = 1'b0;

        // Abort in PRIME, then start+stop together
        pulse_start();
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("lit_abort_busy", busy, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("lit_startstop_busy", busy, 0);
        tick(2);

        // Reset mid-stream then clean restart
        pulse_start();
        tick(12);
        grst = 1'b1;
        tick(1);
        chk("lit_grst_busy", busy, 0);
        chk("lit_grst_bank", bank_sel, 0);
        grst = 1'b0;
        tick(1);
        pulse_start();
        chk("lit_restart_wr_addr", wr_addr, 0);
        chk("lit_restart_busy", busy, 1);
        tick(20);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(20);
        chk("lit_end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
